// File: rtl/nand_page_buf.sv
// nand_page_buf
//   Single-clock page buffer between the host bus and the NAND PHY.
//   Port A: host random access with byte enables (a_en/a_wr/a_be/a_addr/a_din -> a_dout/a_dvalid).
//   Port B: stream engine that fills a page from the PHY (f_tdata/f_tvalid/f_tready) or drains
//           a page to it (m_tdata/m_tvalid/m_tready) through a 2-entry skid FIFO.
//   Control: s_start/s_dir/s_base/s_len in; s_busy, s_done, s_err, coll out.
//
//   state | meaning
//   IDLE  | waiting for s_start
//   FILL  | accepting PHY words into mem[base..base+len-1]
//   DRAIN | streaming mem[base..base+len-1] out to the PHY
//   DONE  | one-cycle completion, s_done high; a new start is accepted here
module nand_page_buf #(
    parameter int DATA     = 32,
    parameter int ADDR     = 10,
    parameter int DEPTH    = 517,
    parameter int RDW_MODE = 0,
    parameter int OUT_REG  = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_en,
    input  logic              a_wr,
    input  logic [DATA/8-1:0] a_be,
    input  logic [ADDR-1:0]   a_addr,
    input  logic [DATA-1:0]   a_din,
    output logic [DATA-1:0]   a_dout,
    output logic              a_dvalid,
    input  logic              s_start,
    input  logic              s_dir,
    input  logic [ADDR-1:0]   s_base,
    input  logic [ADDR:0]     s_len,
    output logic              s_busy,
    output logic              s_done,
    output logic              s_err,
    output logic              coll,
    output logic [DATA-1:0]   m_tdata,
    output logic              m_tvalid,
    input  logic              m_tready,
    input  logic [DATA-1:0]   f_tdata,
    input  logic              f_tvalid,
    output logic              f_tready
);
    localparam int NBE = DATA / 8;
    localparam logic [ADDR+1:0] DEPTH_X = (ADDR+2)'(DEPTH);

    typedef enum logic [1:0] {IDLE, FILL, DRAIN, DONE} state_t;

    state_t            state;
    logic [DATA-1:0]   mem [DEPTH];
    logic [ADDR-1:0]   base_q;
    logic [ADDR:0]     len_q, cnt, iss_cnt, cnt_inc;
    logic [ADDR-1:0]   fill_addr, drain_addr;
    logic [ADDR+1:0]   end_addr;
    logic              start_ok, fill_beat, coll_now, issue, pop, push_vld;
    logic [DATA-1:0]   push_data, rd_word_b;
    logic [DATA-1:0]   fifo0, fifo1;
    logic [1:0]        occ, inflight;
    logic              a_in_range;
    logic [DATA-1:0]   a_rd_old, a_merged, a_d0;
    logic              a_dv0;

    // The range check on start keeps base+cnt below DEPTH, so ADDR bits never wrap.
    assign end_addr   = {2'b00, s_base} + {1'b0, s_len};
    assign start_ok   = (s_len != '0) && (end_addr <= DEPTH_X);
    assign cnt_inc    = cnt + (ADDR+1)'(1);
    assign fill_addr  = base_q + cnt[ADDR-1:0];
    assign drain_addr = base_q + iss_cnt[ADDR-1:0];
    assign fill_beat  = (state == FILL) && f_tready && f_tvalid;
    assign coll_now   = a_en && a_wr && fill_beat && (a_addr == fill_addr);

    assign m_tvalid   = (occ != 2'd0);
    assign m_tdata    = fifo0;
    assign pop        = m_tvalid && m_tready;
    // Reads in flight are counted against FIFO space so a stalled sink never loses a word.
    assign issue      = (state == DRAIN) && (iss_cnt != len_q) && ((occ + inflight) < 2'd2);
    assign rd_word_b  = mem[drain_addr];

    generate
        if (OUT_REG != 0) begin : g_rd_reg
            logic [DATA-1:0] rd_q;
            logic            rd_q_vld;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rd_q     <= '0;
                    rd_q_vld <= 1'b0;
                end else begin
                    rd_q_vld <= issue;
                    if (issue) rd_q <= rd_word_b;
                end
            end
            assign push_vld  = rd_q_vld;
            assign push_data = rd_q;
            assign inflight  = {1'b0, rd_q_vld};
        end else begin : g_rd_comb
            assign push_vld  = issue;
            assign push_data = rd_word_b;
            assign inflight  = 2'd0;
        end
    endgenerate

    // Port A: the read sees the word before this cycle's writes land.
    assign a_in_range = ({2'b00, a_addr} < DEPTH_X);
    assign a_rd_old   = a_in_range ? mem[a_addr] : '0;

    always_comb begin
        a_merged = a_rd_old;
        for (int i = 0; i < NBE; i++)
            if (a_be[i]) a_merged[8*i +: 8] = a_din[8*i +: 8];
    end

    // On a collision the fill write owns the whole word.
    always_ff @(posedge clk) begin
        if (a_en && a_wr && a_in_range && !coll_now)
            for (int i = 0; i < NBE; i++)
                if (a_be[i]) mem[a_addr][8*i +: 8] <= a_din[8*i +: 8];
        if (fill_beat) mem[fill_addr] <= f_tdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_d0  <= '0;
            a_dv0 <= 1'b0;
        end else begin
            a_dv0 <= a_en;
            if (a_en) a_d0 <= (a_wr && RDW_MODE == 0) ? a_merged : a_rd_old;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_a_reg
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_dout   <= '0;
                    a_dvalid <= 1'b0;
                end else begin
                    a_dout   <= a_d0;
                    a_dvalid <= a_dv0;
                end
            end
        end else begin : g_a_comb
            assign a_dout   = a_d0;
            assign a_dvalid = a_dv0;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo0 <= '0;
            fifo1 <= '0;
            occ   <= 2'd0;
        end else begin
            case ({push_vld, pop})
                2'b10: begin
                    if (occ == 2'd0) fifo0 <= push_data;
                    else             fifo1 <= push_data;
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    fifo0 <= fifo1;
                    occ   <= occ - 2'd1;
                end
                2'b11: begin
                    if (occ == 2'd1) fifo0 <= push_data;
                    else begin
                        fifo0 <= fifo1;
                        fifo1 <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            base_q   <= '0;
            len_q    <= '0;
            cnt      <= '0;
            iss_cnt  <= '0;
            s_busy   <= 1'b0;
            s_done   <= 1'b0;
            s_err    <= 1'b0;
            coll     <= 1'b0;
            f_tready <= 1'b0;
        end else begin
            s_done <= 1'b0;
            s_err  <= 1'b0;
            coll   <= coll_now;
            case (state)
                IDLE, DONE: begin
                    state <= IDLE;
                    if (s_start) begin
                        if (start_ok) begin
                            base_q   <= s_base;
                            len_q    <= s_len;
                            cnt      <= '0;
                            iss_cnt  <= '0;
                            s_busy   <= 1'b1;
                            f_tready <= s_dir;
                            state    <= s_dir ? FILL : DRAIN;
                        end else begin
                            s_err <= 1'b1;
                        end
                    end
                end
                FILL: begin
                    if (fill_beat) begin
                        cnt <= cnt_inc;
                        if (cnt_inc == len_q) begin
                            f_tready <= 1'b0;
                            s_busy   <= 1'b0;
                            s_done   <= 1'b1;
                            state    <= DONE;
                        end
                    end
                end
                DRAIN: begin
                    if (issue) iss_cnt <= iss_cnt + (ADDR+1)'(1);
                    if (pop) begin
                        cnt <= cnt_inc;
                        if (cnt_inc == len_q) begin
                            s_busy <= 1'b0;
                            s_done <= 1'b1;
                            state  <= DONE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
